edf_deadline_generator: RTL and testbench
=========================================

# edf_deadline_generator

Producer side of the EDF selection path: keeps one relative-deadline countdown per memory-request queue and turns it into the (value, dispatch) pairs that the `MaxSelector` tree compares. The urgency value rises as the deadline nears, so the tree's maximum is the earliest-deadline queue. The winner's one-hot dispatch vector comes back as the grant and re-arms that queue's deadline.

## Interface
Parameters:
- `NB_QUEUES`, 4: number of request queues (≥2).
- `VAL_WIDTH`, 8: width of period, countdown and urgency value.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high.
- `period_i` in NB_QUEUES*VAL_WIDTH: per-queue relative deadline; queue i occupies slice [i*VAL_WIDTH +: VAL_WIDTH].
- `period_load` in 1: latch `period_i` into the period registers.
- `req` in NB_QUEUES: queue i has a pending request.
- `grant_valid` in 1: a grant is presented this cycle.
- `grant_dis` in NB_QUEUES: one-hot grant vector (the selector's `dis` output).
- `val_o` out NB_QUEUES*VAL_WIDTH: per-queue urgency value, fed to the selector `val` inputs.
- `dis_o` out NB_QUEUES*NB_QUEUES: per-queue one-hot identity, fed to the selector `dis` inputs.
- `miss_o` out NB_QUEUES: one-cycle deadline-miss pulse per queue.
- `miss_cnt_o` out NB_QUEUES*16: saturating miss counters; present only with `DEADLINE_MISS_CNT_EN`.

## Operation
- Per queue: period register `per[i]` and countdown `rem[i]`. Each queue is in one of two states: COUNT (rem>0) or EXPIRED (rem==0).
- Reset: `per` = all ones, `rem` = all ones, `val_o` = 0, `dis_o` = 0, `miss_o` = 0, `miss_cnt_o` = 0.
- `period_load`: `per[i]` ← `period_i` slice. A slice value of 0 is stored as 1.
- Per-cycle update of `rem[i]`, highest priority first:
  1. Queue granted (`grant_valid & grant_dis[i]`): `rem` ← period. If `period_load` is also high this cycle, use the new `period_i` value.
  2. COUNT: `rem` ← rem−1. If rem==1 and `req[i]`=1, go to EXPIRED and pulse `miss_o[i]` on the next cycle.
  3. EXPIRED with `req[i]`=1: hold at 0; no further miss pulses.
  4. EXPIRED with `req[i]`=0: `rem` ← period, starting a new window.
  Also, COUNT reaching 0 with `req[i]`=0 silently enters EXPIRED; rule 4 reloads it on the next cycle.
- Urgency: `val_o[i]` = `req[i]` ? (2^VAL_WIDTH−1 − rem[i]) : 0.
  - Unsigned arithmetic, no overflow possible.
  - An expired pending queue reports all ones.
- Dispatch: `dis_o[i]` = `req[i]` ? (1<<i) : 0.
- Grant handling:
  - `grant_valid` with `grant_dis`==0 is ignored.
  - Multiple set bits re-arm every flagged queue.
  - A grant to a queue with `req`=0 still re-arms it.

## Timing
- `val_o`, `dis_o` and `miss_o` are registered. Each reflects the `req` and `rem` values of the previous cycle (1-cycle latency).
- From grant to updated `val_o`: 2 cycles. Cycle n+1 holds the reloaded `rem`; `val_o` shows it at cycle n+2.
- A `period_load` without a grant does not disturb a running countdown. The new period takes effect at the next reload.
- Reset asserted mid-countdown clears all state immediately, independent of `clk`.

## Configuration
- `DEADLINE_MISS_CNT_EN` defined:
  - Each queue has a 16-bit counter that increments on every `miss_o` pulse and saturates at 0xFFFF.
  - Counters clear only on reset.
  - `miss_cnt_o` port exists.
- Not defined: no counters and no `miss_cnt_o` port. All other behaviour is identical.

## Structure
- Package `edf_pkg`: `MISS_CNT_WIDTH`=16, default `VAL_WIDTH`, and the queue-state enum (COUNT/EXPIRED).
- Sub-module `deadline_counter`: one instance per queue. It holds `per`, `rem`, state, the miss pulse and the optional counter.
- Top level: generate loop for the instances, plus packing of `val_o` and `dis_o`.

## Test plan
All scenarios use NB_QUEUES=2, VAL_WIDTH=4.
- Reset, then `req`=00 → `val_o`=0, `dis_o`=0, `miss_o`=0. `rem` reloads to 15 each time it reaches 0.
- `period_i`={q1=6,q0=3}, `period_load`, grant both, then `req`=11 → `val_o` q0 ramps 12,13,14. After q0 reaches 0: q0 `miss_o` pulses once and `val_o`[q0]=15 is held. q1 `val_o` ramps 9,10,…
- Same setup, grant q0 while it is expired → 2 cycles later `val_o`[q0]=12 and no new miss pulse.
- `grant_valid`=1 with `grant_dis`=00 → no `rem` change (`val_o` continues its normal ramp).
- Simultaneous `period_load` (q0=5) and grant q0 → q0 `val_o` reads 10 two cycles later.
- With `DEADLINE_MISS_CNT_EN`: force 3 misses on q1 → `miss_cnt_o`[q1]=3, `miss_cnt_o`[q0]=0. Assert reset mid-count → both counters 0.

Source files
------------

// File: rtl/edf_pkg.sv
// Shared constants and queue-state type for the EDF deadline generator.
// Optional miss counters are enabled with DEADLINE_MISS_CNT_EN.
package edf_pkg;

    localparam int MISS_CNT_WIDTH    = 16;
    localparam int DEFAULT_VAL_WIDTH = 8;

    typedef enum logic {
        COUNT   = 1'b0,
        EXPIRED = 1'b1
    } queue_state_t;

endpackage

// File: rtl/deadline_counter.sv
// One queue's relative-deadline countdown, urgency value and miss pulse.
// DEADLINE_MISS_CNT_EN adds a saturating per-queue miss counter.
module deadline_counter
    import edf_pkg::*;
#(
    parameter int VAL_WIDTH = DEFAULT_VAL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [VAL_WIDTH-1:0]      period,
    input  logic                      period_load,
    input  logic                      req,
    input  logic                      grant,
    output logic [VAL_WIDTH-1:0]      val,
    output logic                      pending,
`ifdef DEADLINE_MISS_CNT_EN
    output logic                      miss,
    output logic [MISS_CNT_WIDTH-1:0] miss_cnt
`else
    output logic                      miss
`endif
);

    localparam logic [VAL_WIDTH-1:0] VAL_MAX = '1;
    localparam logic [VAL_WIDTH-1:0] VAL_ONE = VAL_WIDTH'(1);

    logic [VAL_WIDTH-1:0] per_q;
    logic [VAL_WIDTH-1:0] per_d;
    logic [VAL_WIDTH-1:0] rem_q;
    logic [VAL_WIDTH-1:0] rem_d;
    logic [VAL_WIDTH-1:0] period_fixed;
    logic [VAL_WIDTH-1:0] reload;
    logic [VAL_WIDTH-1:0] val_d;
    logic                 miss_d;
    queue_state_t         state;

    // A zero period would never count, so it is stored as one.
    assign period_fixed = (period == '0) ? VAL_ONE : period;
    assign reload       = period_load ? period_fixed : per_q;
    assign state        = (rem_q == '0) ? EXPIRED : COUNT;

    always_comb begin
        per_d  = per_q;
        rem_d  = rem_q;
        miss_d = 1'b0;
        val_d  = req ? (VAL_MAX - rem_q) : '0;

        if (period_load) begin
            per_d = period_fixed;
        end

        if (grant) begin
            rem_d = reload;
        end else begin
            unique case (state)
                COUNT: begin
                    rem_d = rem_q - VAL_ONE;
                    if ((rem_q == VAL_ONE) && req) begin
                        miss_d = 1'b1;
                    end
                end
                EXPIRED: begin
                    if (!req) begin
                        rem_d = reload;
                    end
                end
                default: rem_d = rem_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_q   <= '1;
            rem_q   <= '1;
            val     <= '0;
            pending <= 1'b0;
            miss    <= 1'b0;
        end else begin
            per_q   <= per_d;
            rem_q   <= rem_d;
            val     <= val_d;
            pending <= req;
            miss    <= miss_d;
        end
    end

`ifdef DEADLINE_MISS_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt <= '0;
        end else if (miss && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + MISS_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: rtl/edf_deadline_generator.sv
// Per-queue EDF urgency/dispatch producer feeding the MaxSelector tree.
// Define DEADLINE_MISS_CNT_EN to expose saturating miss counters on miss_cnt_o.
module edf_deadline_generator
    import edf_pkg::*;
#(
    parameter int NB_QUEUES = 4,
    parameter int VAL_WIDTH = DEFAULT_VAL_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NB_QUEUES*VAL_WIDTH-1:0]      period_i,
    input  logic                                period_load,
    input  logic [NB_QUEUES-1:0]                req,
    input  logic                                grant_valid,
    input  logic [NB_QUEUES-1:0]                grant_dis,
    output logic [NB_QUEUES*VAL_WIDTH-1:0]      val_o,
    output logic [NB_QUEUES*NB_QUEUES-1:0]      dis_o,
`ifdef DEADLINE_MISS_CNT_EN
    output logic [NB_QUEUES-1:0]                miss_o,
    output logic [NB_QUEUES*MISS_CNT_WIDTH-1:0] miss_cnt_o
`else
    output logic [NB_QUEUES-1:0]                miss_o
`endif
);

    logic [NB_QUEUES-1:0] pending;

    for (genvar i = 0; i < NB_QUEUES; i++) begin : g_queue
        deadline_counter #(
            .VAL_WIDTH (VAL_WIDTH)
        ) u_counter (
            .clk         (clk),
            .reset       (reset),
            .period      (period_i[i*VAL_WIDTH +: VAL_WIDTH]),
            .period_load (period_load),
            .req         (req[i]),
            .grant       (grant_valid & grant_dis[i]),
            .val         (val_o[i*VAL_WIDTH +: VAL_WIDTH]),
            .pending     (pending[i]),
`ifdef DEADLINE_MISS_CNT_EN
            .miss        (miss_o[i]),
            .miss_cnt    (miss_cnt_o[i*MISS_CNT_WIDTH +: MISS_CNT_WIDTH])
`else
            .miss        (miss_o[i])
`endif
        );

        // The registered request bit gates the queue's one-hot identity.
        assign dis_o[i*NB_QUEUES +: NB_QUEUES] =
            pending[i] ? (NB_QUEUES'(1) << i) : '0;
    end

endmodule

// File: tb/tb_edf_deadline_generator.sv
// Directed bench for edf_deadline_generator with two queues and 4-bit values.
// Counter checks are active when DEADLINE_MISS_CNT_EN is defined.
module tb_edf_deadline_generator;

    localparam int NB = 2;
    localparam int W  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB*W-1:0] period_i;
    logic          period_load;
    logic [NB-1:0] req;
    logic          grant_valid;
    logic [NB-1:0] grant_dis;
    logic [NB*W-1:0] val_o;
    logic [NB*NB-1:0] dis_o;
    logic [NB-1:0] miss_o;
`ifdef DEADLINE_MISS_CNT_EN
    logic [NB*16-1:0] miss_cnt_o;
`endif

    int compared   = 0;
    int mismatched = 0;

    edf_deadline_generator #(
        .NB_QUEUES (NB),
        .VAL_WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .period_i    (period_i),
        .period_load (period_load),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_dis   (grant_dis),
        .val_o       (val_o),
        .dis_o       (dis_o),
`ifdef DEADLINE_MISS_CNT_EN
        .miss_o      (miss_o),
        .miss_cnt_o  (miss_cnt_o)
`else
        .miss_o      (miss_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [NB-1:0] r, input logic gv,
                                  input logic [NB-1:0] gd, input logic pl,
                                  input logic [NB*W-1:0] p);
        req         = r;
        grant_valid = gv;
        grant_dis   = gd;
        period_load = pl;
        period_i    = p;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_step(input string tag, input logic [NB*W-1:0] exp_val,
                              input logic [NB*NB-1:0] exp_dis, input logic [NB-1:0] exp_miss);
        check_output({tag, ".val"},  32'(val_o),  32'(exp_val));
        check_output({tag, ".dis"},  32'(dis_o),  32'(exp_dis));
        check_output({tag, ".miss"}, 32'(miss_o), 32'(exp_miss));
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(2'b00, 1'b0, 2'b00, 1'b0, 8'h00);
        #12;
        check_step("reset", 8'h00, 4'b0000, 2'b00);
`ifdef DEADLINE_MISS_CNT_EN
        check_output("reset.cnt", miss_cnt_o, 32'h0);
`endif
        reset = 1'b0;

        // Idle queues: outputs stay zero while rem wraps 15..0 and reloads to 15.
        for (int k = 0; k < 17; k++) begin
            tick();
            check_step("idle", 8'h00, 4'b0000, 2'b00);
        end
        apply_stimulus(2'b01, 1'b0, 2'b00, 1'b0, 8'h00);
        tick();
        check_step("reload15", 8'h01, 4'b0001, 2'b00);

        // Load periods {6,3}, grant both, then ramp with both requesting.
        apply_stimulus(2'b00, 1'b1, 2'b11, 1'b1, 8'h63);
        tick();
        check_step("load", 8'h00, 4'b0000, 2'b00);
        apply_stimulus(2'b11, 1'b0, 2'b00, 1'b0, 8'h63);
        tick(); check_step("ramp0", 8'h9C, 4'b1001, 2'b00);
        tick(); check_step("ramp1", 8'hAD, 4'b1001, 2'b00);
        tick(); check_step("ramp2", 8'hBE, 4'b1001, 2'b01);
        tick(); check_step("exp0a", 8'hCF, 4'b1001, 2'b00);
        tick(); check_step("exp0b", 8'hDF, 4'b1001, 2'b00);
        tick(); check_step("miss1", 8'hEF, 4'b1001, 2'b10);
        tick(); check_step("both_exp", 8'hFF, 4'b1001, 2'b00);

        // Grant q0 while expired.
        apply_stimulus(2'b11, 1'b1, 2'b01, 1'b0, 8'h63);
        tick(); check_step("gexp_n1", 8'hFF, 4'b1001, 2'b00);
        apply_stimulus(2'b11, 1'b0, 2'b00, 1'b0, 8'h63);
        tick(); check_step("gexp_n2", 8'hFC, 4'b1001, 2'b00);

        // Empty grant vector is ignored.
        apply_stimulus(2'b11, 1'b1, 2'b00, 1'b0, 8'h63);
        tick(); check_step("gnone", 8'hFD, 4'b1001, 2'b00);
        apply_stimulus(2'b11, 1'b0, 2'b00, 1'b0, 8'h63);
        tick(); check_step("gnone_n1", 8'hFE, 4'b1001, 2'b01);
        tick(); check_step("gnone_n2", 8'hFF, 4'b1001, 2'b00);

        // Simultaneous load of q0=5 and grant q0 uses the new period.
        apply_stimulus(2'b11, 1'b1, 2'b01, 1'b1, 8'h65);
        tick(); check_step("ldg_n1", 8'hFF, 4'b1001, 2'b00);
        apply_stimulus(2'b11, 1'b0, 2'b00, 1'b0, 8'h65);
        tick(); check_step("ldg_n2", 8'hFA, 4'b1001, 2'b00);
        tick(); check_step("ldg_n3", 8'hFB, 4'b1001, 2'b00);
`ifdef DEADLINE_MISS_CNT_EN
        check_output("cnt_pre", miss_cnt_o, 32'h0001_0002);
`endif

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check_step("async_rst", 8'h00, 4'b0000, 2'b00);
`ifdef DEADLINE_MISS_CNT_EN
        check_output("async_rst.cnt", miss_cnt_o, 32'h0);
`endif
        reset = 1'b0;

        // Three forced misses on q1 with period 2; q0 idle.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(2'b10, 1'b1, 2'b10, 1'b1, 8'h2F);
            tick();
            apply_stimulus(2'b10, 1'b0, 2'b00, 1'b0, 8'h2F);
            tick();
            check_output("force.premiss", 32'(miss_o), 32'h0);
            tick();
            check_output("force.miss", 32'(miss_o), 32'h2);
        end
        apply_stimulus(2'b10, 1'b0, 2'b00, 1'b0, 8'h2F);
        tick();
        check_output("force.after", 32'(miss_o), 32'h0);
`ifdef DEADLINE_MISS_CNT_EN
        check_output("cnt3", miss_cnt_o, 32'h0003_0000);
        #2;
        reset = 1'b1;
        #1;
        check_output("cnt_rst", miss_cnt_o, 32'h0);
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
